// File: rtl/bufgctrl_switch_pkg.sv
// Shared types and constants for the clock-buffer switch sequencer.
//   state_t       : sequencer states
//   CYC_MIN/MAX   : legal range for the drain/settle cycle parameters
//   cnt_width()   : down-counter width for the given drain/settle lengths
//   clamp_cycles(): forces a cycle parameter into the legal range
package bufgctrl_switch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int CYC_MIN = 1;
  localparam int CYC_MAX = 255;

  function automatic int clamp_cycles(input int cycles);
    if (cycles < CYC_MIN) return CYC_MIN;
    if (cycles > CYC_MAX) return CYC_MAX;
    return cycles;
  endfunction

  function automatic int cnt_width(input int drain, input int settle);
    int m;
    m = (drain > settle) ? drain : settle;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bufgctrl_switch_ctrl_if.sv
// Request/acknowledge handshake between clock-management logic and the
// clock-buffer switch sequencer.
//   req_valid  : single-cycle switch request
//   req_sel    : requested input (0 = I0, 1 = I1)
//   ack        : one-cycle completion/rejection pulse
//   err        : one-cycle pulse with ack on rejection
//   busy       : switch sequence in progress
//   active_sel : currently committed input
interface bufgctrl_switch_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic ack;
  logic err;
  logic busy;
  logic active_sel;

  modport master (
    output req_valid, req_sel,
    input  ack, err, busy, active_sel
  );

  modport slave (
    input  req_valid, req_sel,
    output ack, err, busy, active_sel
  );
endinterface

// File: rtl/bufgctrl_switch_cnt.sv
// Loadable down-counter with zero flag, shared by the drain and settle phases.
//   clk, rst_n : control clock, async active-low reset
//   load       : load load_val (has priority over counting)
//   load_val   : value to load
//   zero       : counter is 0 (counter holds at 0, never wraps)
module bufgctrl_switch_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bufgctrl_switch_ctrl.sv
// Sequencer for the select/enable pins of a glitch-free dual-input clock
// buffer. A switch request is turned into deselect -> drain -> select ->
// settle, then acknowledged. All outputs are registered.
//
// Optional feature macro: BUFGCTRL_SWITCH_IGNORE_EN
//   When defined, an outgoing clock that is unhealthy at acceptance has its
//   IGNORE pin raised for the duration of the switch so the buffer can leave
//   a dead clock. When undefined, ignore0/ignore1 are constant 0.
//
// Ports:
//   clk, rst_n         : control clock, async active-low reset
//   bus (slave)        : req_valid/req_sel in; ack/err/busy/active_sel out
//   clk0_ok, clk1_ok   : input health, synchronous to clk
//   ce0, ce1, s0, s1   : buffer enable/select pins
//   ignore0, ignore1   : buffer ignore pins
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | committed input selected, accepting requests
// ST_DRAIN  | both inputs deselected, waiting DRAIN_CYCLES
// ST_SETTLE | target selected, waiting SETTLE_CYCLES before ack
module bufgctrl_switch_ctrl
  import bufgctrl_switch_pkg::*;
#(
  parameter int INIT_SEL      = 0,
  parameter int DRAIN_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bufgctrl_switch_ctrl_if.slave  bus,
  input  logic                   clk0_ok,
  input  logic                   clk1_ok,
  output logic                   ce0,
  output logic                   ce1,
  output logic                   s0,
  output logic                   s1,
  output logic                   ignore0,
  output logic                   ignore1
);

  localparam int DRAIN_EFF  = clamp_cycles(DRAIN_CYCLES);
  localparam int SETTLE_EFF = clamp_cycles(SETTLE_CYCLES);
  localparam int CW         = cnt_width(DRAIN_EFF, SETTLE_EFF);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_EFF - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_EFF - 1);
  localparam logic INIT_BIT = (INIT_SEL != 0);
  localparam logic [1:0] INIT_CE = INIT_BIT ? 2'b10 : 2'b01;

  state_t        state_q, state_nxt;
  logic          tgt_q, tgt_nxt;
  logic          active_q, active_nxt;
  logic          ack_q, ack_nxt;
  logic          err_q, err_nxt;
  logic          busy_q, busy_nxt;
  // ce and s always move together; index 0 is I0, index 1 is I1
  logic [1:0]    ce_q, ce_nxt;
  logic [1:0]    ign_q, ign_nxt;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          tgt_ok;

  bufgctrl_switch_cnt #(.WIDTH(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  assign tgt_ok = bus.req_sel ? clk1_ok : clk0_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tgt_q    <= INIT_BIT;
      active_q <= INIT_BIT;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ce_q     <= INIT_CE;
      ign_q    <= 2'b00;
    end else begin
      state_q  <= state_nxt;
      tgt_q    <= tgt_nxt;
      active_q <= active_nxt;
      ack_q    <= ack_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
      ce_q     <= ce_nxt;
      ign_q    <= ign_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    tgt_nxt    = tgt_q;
    active_nxt = active_q;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    busy_nxt   = busy_q;
    ce_nxt     = ce_q;
    ign_nxt    = ign_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_sel == active_q) begin
            ack_nxt = 1'b1;
          end else if (!tgt_ok) begin
            ack_nxt = 1'b1;
            err_nxt = 1'b1;
          end else begin
            tgt_nxt   = bus.req_sel;
            state_nxt = ST_DRAIN;
            busy_nxt  = 1'b1;
            ce_nxt    = 2'b00;
            cnt_load  = 1'b1;
            cnt_val   = DRAIN_LD;
`ifdef BUFGCTRL_SWITCH_IGNORE_EN
            ign_nxt[active_q] = ~(active_q ? clk1_ok : clk0_ok);
`endif
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_zero) begin
          state_nxt      = ST_SETTLE;
          ce_nxt[tgt_q]  = 1'b1;
          cnt_load       = 1'b1;
          cnt_val        = SETTLE_LD;
        end
      end

      ST_SETTLE: begin
        if (cnt_zero) begin
          state_nxt  = ST_IDLE;
          active_nxt = tgt_q;
          ack_nxt    = 1'b1;
          busy_nxt   = 1'b0;
          ign_nxt    = 2'b00;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.ack        = ack_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.active_sel = active_q;
  assign ce0     = ce_q[0];
  assign s0      = ce_q[0];
  assign ce1     = ce_q[1];
  assign s1      = ce_q[1];
  assign ignore0 = ign_q[0];
  assign ignore1 = ign_q[1];

endmodule
